// File: rtl/rc4_ksa_swap.sv
// RC4 key-scheduling swap phase: walks i = 0..255 over the S memory, swapping S[i] with S[j].
// Optional macro RC4_KSA_SKIP_SELF_SWAP_EN skips both write cycles whenever j == i.
module rc4_ksa_swap #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    input  logic [7:0]             q,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        LD_I,
        WT_J,
        LD_J,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } state_t;

    localparam logic [7:0] KEY_LEN = 8'(KEY_BYTES);

    state_t     state, state_next;
    logic [7:0] i, i_next;
    logic [7:0] j, j_next;
    logic [7:0] si, si_next;
    logic [7:0] sj, sj_next;
    logic [7:0] address_next;
    logic [7:0] data_next;
    logic       wren_next;
    logic       busy_next;
    logic       done_next;

    logic [7:0] key_idx;
    logic [7:0] key_byte;
    logic [7:0] j_sum;

    // Byte 0 of the key sits in the most significant byte of secret_key.
    assign key_idx = i % KEY_LEN;

    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (key_idx == 8'(k)) begin
                key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
            end
        end
    end

    assign j_sum = j + q + key_byte;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            i       <= 8'h00;
            j       <= 8'h00;
            si      <= 8'h00;
            sj      <= 8'h00;
            address <= 8'h00;
            data    <= 8'h00;
            wren    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            i       <= i_next;
            j       <= j_next;
            si      <= si_next;
            sj      <= sj_next;
            address <= address_next;
            data    <= data_next;
            wren    <= wren_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        i_next       = i;
        j_next       = j;
        si_next      = si;
        sj_next      = sj;
        address_next = address;
        data_next    = data;
        wren_next    = wren;
        busy_next    = busy;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    i_next     = 8'h00;
                    j_next     = 8'h00;
                    busy_next  = 1'b1;
                    state_next = RD_I;
                end
            end
            RD_I: begin
                address_next = i;
                wren_next    = 1'b0;
                state_next   = WT_I;
            end
            WT_I: state_next = LD_I;
            LD_I: begin
                si_next      = q;
                j_next       = j_sum;
                address_next = j_sum;
                state_next   = WT_J;
            end
            WT_J: state_next = LD_J;
            LD_J: begin
                sj_next    = q;
`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
                state_next = (j == i) ? NEXT : WR_I;
`else
                state_next = WR_I;
`endif
            end
            WR_I: begin
                address_next = i;
                data_next    = sj;
                wren_next    = 1'b1;
                state_next   = WR_J;
            end
            WR_J: begin
                address_next = j;
                data_next    = si;
                wren_next    = 1'b1;
                state_next   = NEXT;
            end
            NEXT: begin
                wren_next = 1'b0;
                if (i == 8'hFF) begin
                    state_next = DONE;
                end else begin
                    i_next     = i + 8'h01;
                    state_next = RD_I;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                wren_next  = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_ksa_swap.sv
// Self-checking bench for rc4_ksa_swap: models the S RAM and compares against a software RC4 KSA.
// Honours RC4_KSA_SKIP_SELF_SWAP_EN when computing expected writes and latency.
module tb_rc4_ksa_swap;

`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic [7:0]  q;
    logic        busy;
    logic        done;

    logic        prefill;
    logic [7:0]  mem [256];
    logic [7:0]  ref_s [256];
    logic [15:0] exp_q [$];
    logic [15:0] wr_q [$];
    int          self_swaps;
    int          vectors = 0;
    int          miscompares = 0;

    rc4_ksa_swap #(.KEY_BYTES(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .secret_key(secret_key),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Single-port synchronous S RAM with one clock of read latency.
    always @(posedge CLOCK_50) begin
        if (prefill) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else begin
            if (wren) mem[address] <= data;
            q <= mem[address];
        end
    end

    always @(posedge CLOCK_50) begin
        if (wren) wr_q.push_back({address, data});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic prefillMem();
        @(negedge CLOCK_50) prefill = 1'b1;
        @(negedge CLOCK_50) prefill = 1'b0;
    endtask

    // Plain RC4 KSA over the current memory image; records the expected write stream.
    task automatic buildModel(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] jj;
        logic [7:0] t;
        jj = 8'h00;
        self_swaps = 0;
        exp_q.delete();
        for (int k = 0; k < 256; k++) s[k] = mem[k];
        for (int ii = 0; ii < 256; ii++) begin
            jj = 8'(jj + s[ii] + key[23-8*(ii%3) -: 8]);
            if (jj == 8'(ii)) self_swaps++;
            if (!(SKIP && jj == 8'(ii))) begin
                exp_q.push_back({8'(ii), s[jj]});
                exp_q.push_back({jj, s[ii]});
            end
            t = s[ii];
            s[ii] = s[jj];
            s[jj] = t;
        end
        for (int k = 0; k < 256; k++) ref_s[k] = s[k];
    endtask

    task automatic applyStimulus(input logic [23:0] key, input bit glitch, input bit zero_check);
        int n;
        int busy_cnt;
        int exp_lat;
        int early_n;
        int done_cnt;
        bit seen;
        secret_key = key;
        buildModel(key);
        exp_lat = SKIP ? 2049 - 2 * self_swaps : 2049;
        early_n = SKIP ? 20 : 24;
        @(negedge CLOCK_50);
        wr_q.delete();
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        n = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(posedge CLOCK_50);
            #1 n++;
            start = glitch && (n == 10 || n == 500);
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
            if (zero_check && n == early_n) checkOutput("early_S2", 32'(mem[2]), 32'h3);
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(seen), 32'h1);
        checkOutput("latency", 32'(n), 32'(exp_lat));
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        checkOutput("busy_at_done", 32'(busy), 32'h0);
        @(posedge CLOCK_50);
        #1 checkOutput("done_after", 32'(done), 32'h0);
        done_cnt = 0;
        repeat (20) begin
            @(posedge CLOCK_50);
            #1 if (done) done_cnt++;
        end
        checkOutput("extra_done", 32'(done_cnt), 32'h0);
        checkOutput("write_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++)
            checkOutput($sformatf("write%0d", k), 32'(wr_q[k]), 32'(exp_q[k]));
        for (int k = 0; k < 256; k++)
            checkOutput($sformatf("S[%0d]", k), 32'(mem[k]), 32'(ref_s[k]));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        prefill = 1'b1;
        secret_key = 24'h010203;
        repeat (3) @(posedge CLOCK_50);
        #1 prefill = 1'b0;
        checkOutput("rst_address", 32'(address), 32'h0);
        checkOutput("rst_data", 32'(data), 32'h0);
        checkOutput("rst_wren", 32'(wren), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        @(negedge CLOCK_50) reset = 1'b0;

        // Mid-run reset, after checking the first two write pairs.
        $display("[TB] mid-run reset");
        @(negedge CLOCK_50);
        wr_q.delete();
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        repeat (100) @(posedge CLOCK_50);
        #1 reset = 1'b1;
        @(posedge CLOCK_50);
        #1 checkOutput("midrst_wren", 32'(wren), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_done", 32'(done), 32'h0);
        checkOutput("midrst_address", 32'(address), 32'h0);
        checkOutput("first_writes", 32'(wr_q.size() >= 4), 32'h1);
        if (wr_q.size() >= 4) begin
            checkOutput("w0", 32'(wr_q[0]), 32'h0001);
            checkOutput("w1", 32'(wr_q[1]), 32'h0100);
            checkOutput("w2", 32'(wr_q[2]), 32'h0103);
            checkOutput("w3", 32'(wr_q[3]), 32'h0300);
        end
        @(negedge CLOCK_50) reset = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1 checkOutput("post_rst_wren", 32'(wren), 32'h0);

        // Restart from the partially swapped image, with stray start pulses.
        $display("[TB] restart after reset with ignored starts");
        applyStimulus(24'h010203, 1'b1, 1'b0);

        $display("[TB] zero key");
        prefillMem();
        applyStimulus(24'h000000, 1'b0, 1'b1);

        $display("[TB] key 4A3F1C");
        prefillMem();
        applyStimulus(24'h4A3F1C, 1'b0, 1'b0);

        $display("[TB] random keys");
        repeat (2) begin
            prefillMem();
            applyStimulus(24'($urandom), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
